// File: rtl/conv_maxpool_engine_if.sv
// Shared result-memory port plus the ready/busy start handshake of the
// layer-1 max-pool stage. The engine uses the master view; the host and
// memory side use the slave view.
interface conv_maxpool_engine_if #(
  parameter int DATA_W = 20
);
  logic              ready;
  logic              busy;
  logic              crd;
  logic [11:0]       caddr_rd;
  logic [DATA_W-1:0] cdata_rd;
  logic              cwr;
  logic [11:0]       caddr_wr;
  logic [DATA_W-1:0] cdata_wr;
  logic [2:0]        csel;

  modport master (
    input  ready, cdata_rd,
    output busy, crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel
  );

  modport slave (
    output ready, cdata_rd,
    input  busy, crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel
  );
endinterface

// File: rtl/conv_maxpool_engine.sv
// Layer-1 stage: 2x2/stride-2 max pooling of the two 64x64 layer-0 maps
// into two 32x32 maps, with optional round-up to the next integer.
// Each output pixel takes five cycles: four window reads then one write.
module conv_maxpool_engine #(
  parameter int DATA_W  = 20,
  parameter int FRAC_W  = 16,
  parameter int CEIL_EN = 1
) (
  input logic                   clk,
  input logic                   reset,
  conv_maxpool_engine_if.master bus
);
  localparam int               INT_W   = DATA_W - FRAC_W;
  localparam logic [INT_W-1:0] INT_ONE = INT_W'(1);
  localparam logic [9:0]       O_LAST  = 10'd1023;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD0,
    S_RD1,
    S_RD2,
    S_RD3,
    S_WR
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [9:0]        r_o, w_o_nxt;
  logic              r_ch, w_ch_nxt;

  logic [DATA_W-1:0] r_max;
  logic [DATA_W-1:0] w_max4;
  logic [DATA_W-1:0] w_pooled;
  logic [INT_W-1:0]  w_int_up;

  logic              r_busy, w_busy_nxt;
  logic              r_crd, w_crd_nxt;
  logic              r_cwr, w_cwr_nxt;
  logic [2:0]        r_csel, w_csel_nxt;
  logic [11:0]       r_caddr_rd, w_caddr_rd_nxt;
  logic [11:0]       r_caddr_wr, w_caddr_wr_nxt;
  logic [DATA_W-1:0] r_cdata_wr, w_cdata_wr_nxt;
  logic [1:0]        w_k;

  // State register together with the output-pixel index and channel.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_o     <= '0;
      r_ch    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_o     <= w_o_nxt;
      r_ch    <= w_ch_nxt;
    end
  end

  // Next state: four reads then a write per pixel; pixel/channel advance on WR.
  always_comb begin
    w_state_nxt = r_state;
    w_o_nxt     = r_o;
    w_ch_nxt    = r_ch;
    case (r_state)
      S_IDLE: if (bus.ready) w_state_nxt = S_RD0;
      S_RD0:  w_state_nxt = S_RD1;
      S_RD1:  w_state_nxt = S_RD2;
      S_RD2:  w_state_nxt = S_RD3;
      S_RD3:  w_state_nxt = S_WR;
      S_WR: begin
        if (r_o == O_LAST) begin
          w_o_nxt = '0;
          if (r_ch) begin
            w_state_nxt = S_IDLE;
            w_ch_nxt    = 1'b0;
          end else begin
            w_state_nxt = S_RD0;
            w_ch_nxt    = 1'b1;
          end
        end else begin
          w_o_nxt     = r_o + 10'd1;
          w_state_nxt = S_RD0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode from the state being entered, so every output is a
  // register that already shows the new state's values on the entering edge.
  always_comb begin
    w_busy_nxt     = (w_state_nxt != S_IDLE);
    w_crd_nxt      = 1'b0;
    w_cwr_nxt      = 1'b0;
    w_csel_nxt     = r_csel;
    w_caddr_rd_nxt = r_caddr_rd;
    w_caddr_wr_nxt = r_caddr_wr;
    w_cdata_wr_nxt = r_cdata_wr;
    w_k            = 2'b00;
    case (w_state_nxt)
      S_RD0, S_RD1, S_RD2, S_RD3: begin
        case (w_state_nxt)
          S_RD1:   w_k = 2'b01;
          S_RD2:   w_k = 2'b10;
          S_RD3:   w_k = 2'b11;
          default: w_k = 2'b00;
        endcase
        w_crd_nxt      = 1'b1;
        w_csel_nxt     = w_ch_nxt ? 3'b010 : 3'b001;
        w_caddr_rd_nxt = {w_o_nxt[9:5], w_k[1], w_o_nxt[4:0], w_k[0]};
      end
      S_WR: begin
        w_cwr_nxt      = 1'b1;
        w_csel_nxt     = w_ch_nxt ? 3'b100 : 3'b011;
        w_caddr_wr_nxt = {2'b00, w_o_nxt};
        w_cdata_wr_nxt = w_pooled;
      end
      default: ;
    endcase
  end

  // Registered memory-port and handshake outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy     <= 1'b0;
      r_crd      <= 1'b0;
      r_cwr      <= 1'b0;
      r_csel     <= '0;
      r_caddr_rd <= '0;
      r_caddr_wr <= '0;
      r_cdata_wr <= '0;
    end else begin
      r_busy     <= w_busy_nxt;
      r_crd      <= w_crd_nxt;
      r_cwr      <= w_cwr_nxt;
      r_csel     <= w_csel_nxt;
      r_caddr_rd <= w_caddr_rd_nxt;
      r_caddr_wr <= w_caddr_wr_nxt;
      r_cdata_wr <= w_cdata_wr_nxt;
    end
  end

  // Compare the incoming sample with the running maximum.
  always_comb begin
    w_max4 = (bus.cdata_rd > r_max) ? bus.cdata_rd : r_max;
  end

  // Running maximum: seeded by the RD0 sample, folded with RD1..RD3 samples.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_max <= '0;
    end else if (r_state == S_RD0) begin
      r_max <= bus.cdata_rd;
    end else if (r_state == S_RD1 || r_state == S_RD2 || r_state == S_RD3) begin
      r_max <= w_max4;
    end
  end

  // Round up to the next integer when any fraction bit is set; an integer
  // overflow wraps to zero.
  always_comb begin
    w_int_up = w_max4[DATA_W-1:FRAC_W] + INT_ONE;
    w_pooled = w_max4;
    if (CEIL_EN != 0 && w_max4[FRAC_W-1:0] != '0) begin
      w_pooled = {w_int_up, {FRAC_W{1'b0}}};
    end
  end

  assign bus.busy     = r_busy;
  assign bus.crd      = r_crd;
  assign bus.cwr      = r_cwr;
  assign bus.csel     = r_csel;
  assign bus.caddr_rd = r_caddr_rd;
  assign bus.caddr_wr = r_caddr_wr;
  assign bus.cdata_wr = r_cdata_wr;
endmodule
